// File: rtl/led_mode_sched.sv
// LED mode scheduler: merges host-written base modes with timed, prioritised
// override events and presents 16 packed 2-bit mode codes to the matrix driver.
// Overrides age once per tick; a 16-cycle sweep walks every LED and retires
// expired entries. Event interface (valid/ready): an event transfers on any
// rising clk edge where evt_valid && evt_ready. The requester keeps evt_valid
// and all evt_* fields stable until that edge. evt_ready is high only while
// the scheduler is idle and never during reset.
module led_mode_sched #(
  parameter int TICK_CYCLES = 100000,
  parameter int HOLD_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [3:0]        evt_led,
  input  logic [1:0]        evt_mode,
  input  logic              evt_prio,
  input  logic [HOLD_W-1:0] evt_hold,
  input  logic              clr_ovr,
  output logic [31:0]       led_mode,
  output logic [15:0]       ovr_active,
  output logic              dbg_state,
  output logic              dbg_tick_pend
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [3:0]        idx_q, idx_d;
  logic              tick_pend_q, tick_pend_d;
  logic              evt_ready_q, evt_ready_d;
  logic [1:0]        base_q [16];
  logic [1:0]        base_d [16];
  logic [1:0]        ovr_mode_q [16];
  logic [1:0]        ovr_mode_d [16];
  logic [15:0]       ovr_prio_q, ovr_prio_d;
  logic [15:0]       active_q, active_d;
  logic [HOLD_W-1:0] hold_q [16];
  logic [HOLD_W-1:0] hold_d [16];
  logic [31:0]       led_mode_q, led_mode_d;
  logic [15:0]       ovr_active_q;
  logic              tick;
  logic              accept;
  logic              blocked;

  // One-cycle tick pulse when the prescaler wraps.
  assign tick    = (presc_q == PW'(TICK_CYCLES - 1));
  assign accept  = evt_valid && evt_ready_q;
  // A low-priority event may not disturb an active high-priority override.
  assign blocked = active_q[evt_led] && ovr_prio_q[evt_led] && !evt_prio;

  // Next-state logic: prescaler, sweep FSM, host writes, events, clear.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    state_d     = state_q;
    idx_d       = idx_q;
    tick_pend_d = tick_pend_q;
    base_d      = base_q;
    ovr_mode_d  = ovr_mode_q;
    ovr_prio_d  = ovr_prio_q;
    active_d    = active_q;
    hold_d      = hold_q;

    if (wr_en) begin
      base_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (tick || tick_pend_q) begin
          state_d     = S_SWEEP;
          idx_d       = 4'd0;
          tick_pend_d = 1'b0;
        end
      end
      S_SWEEP: begin
        // A tick mid-sweep is remembered and starts another sweep later.
        if (tick) begin
          tick_pend_d = 1'b1;
        end
        if (active_q[idx_q] && (hold_q[idx_q] != '0)) begin
          hold_d[idx_q] = hold_q[idx_q] - HOLD_W'(1);
          if (hold_q[idx_q] == HOLD_W'(1)) begin
            active_d[idx_q] = 1'b0;
          end
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Events are only accepted in IDLE, so they never race the sweep.
    if (accept && !blocked) begin
      if (evt_hold == '0) begin
        active_d[evt_led] = 1'b0;
        hold_d[evt_led]   = '0;
      end else begin
        ovr_mode_d[evt_led] = evt_mode;
        ovr_prio_d[evt_led] = evt_prio;
        hold_d[evt_led]     = evt_hold;
        active_d[evt_led]   = 1'b1;
      end
    end

    // Global clear wins over anything else touching override state.
    if (clr_ovr) begin
      active_d = '0;
      for (int i = 0; i < 16; i++) begin
        hold_d[i] = '0;
      end
    end

    evt_ready_d = (state_d == S_IDLE);
  end

  // Output mux: override mode where active, otherwise the base mode.
  always_comb begin
    led_mode_d = '0;
    for (int i = 0; i < 16; i++) begin
      led_mode_d[2*i +: 2] = active_q[i] ? ovr_mode_q[i] : base_q[i];
    end
  end

  // All state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      tick_pend_q  <= 1'b0;
      evt_ready_q  <= 1'b0;
      ovr_prio_q   <= '0;
      active_q     <= '0;
      led_mode_q   <= '0;
      ovr_active_q <= '0;
      for (int i = 0; i < 16; i++) begin
        base_q[i]     <= '0;
        ovr_mode_q[i] <= '0;
        hold_q[i]     <= '0;
      end
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      tick_pend_q  <= tick_pend_d;
      evt_ready_q  <= evt_ready_d;
      ovr_prio_q   <= ovr_prio_d;
      active_q     <= active_d;
      led_mode_q   <= led_mode_d;
      ovr_active_q <= active_q;
      for (int i = 0; i < 16; i++) begin
        base_q[i]     <= base_d[i];
        ovr_mode_q[i] <= ovr_mode_d[i];
        hold_q[i]     <= hold_d[i];
      end
    end
  end

  assign evt_ready     = evt_ready_q;
  assign led_mode      = led_mode_q;
  assign ovr_active    = ovr_active_q;
  assign dbg_state     = state_q;
  assign dbg_tick_pend = tick_pend_q;

endmodule
